// File: rtl/alu_sequencer.sv
// alu_sequencer: issue/retire stage wrapped around a combinational ALU.
// Latency: the handshake edge moves the instruction into EXEC, and the next edge raises OUT_VALID_o. Peak throughput is 1 instr / 2 cycles.
// Backpressure: OUT_* holds while OUT_READY_i is low. IN_READY_o = OUT_READY_i in RESP, so a retire and an accept can share one edge.
//
// Ports:
//   clk, rst_n               single clock, asynchronous active-low reset
//   IN_VALID_i/IN_READY_o    instruction handshake (IN_INSTR_i, IN_RS1_i, IN_RS2_i)
//   OUT_VALID_o/OUT_READY_i  result handshake (OUT_RESULT_o, OUT_RD_o, OUT_TAKEN_o, OUT_ILLEGAL_o)
//   ALU_OP_o/ALU_RS1_o/ALU_RS2_o  registered operands to the external ALU
//   ALU_RD_i/ALU_ZR_i        combinational ALU result and zero flag, captured at the end of EXEC
//
// Optional feature: define ALU_SEQ_FWD_EN to forward the retiring result into the operands
// of an instruction accepted on the same edge (RESP->EXEC), matched on rs1/rs2 index.

module alu_sequencer #(
  parameter int XLEN = 32,
  parameter int OP_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            IN_VALID_i,
  output logic            IN_READY_o,
  input  logic [31:0]     IN_INSTR_i,
  input  logic [XLEN-1:0] IN_RS1_i,
  input  logic [XLEN-1:0] IN_RS2_i,
  output logic            OUT_VALID_o,
  input  logic            OUT_READY_i,
  output logic [XLEN-1:0] OUT_RESULT_o,
  output logic [4:0]      OUT_RD_o,
  output logic            OUT_TAKEN_o,
  output logic            OUT_ILLEGAL_o,
  output logic [OP_W-1:0] ALU_OP_o,
  output logic [XLEN-1:0] ALU_RS1_o,
  output logic [XLEN-1:0] ALU_RS2_o,
  input  logic [XLEN-1:0] ALU_RD_i,
  input  logic            ALU_ZR_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // How the captured ALU output becomes the taken flag.
  typedef enum logic [2:0] {
    BR_NONE = 3'd0,  // not a branch
    BR_EQ   = 3'd1,  // taken = ZR
    BR_NE   = 3'd2,  // taken = !ZR
    BR_LT   = 3'd3,  // taken = RD[0]
    BR_GE   = 3'd4   // taken = !RD[0]
  } br_t;

  // ALU opcodes. The ALU also implements EQ (0011) and NOR (1001), but no RV32I instruction
  // decodes to them.
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(4'b0000);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(4'b0001);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(4'b0010);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(4'b0100);
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(4'b0101);
  localparam logic [OP_W-1:0] OP_SRA  = OP_W'(4'b0111);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4'b1000);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(4'b1010);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(4'b1110);
  localparam logic [OP_W-1:0] OP_SLTU = OP_W'(4'b1111);

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_B   = 7'b1100011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t          state_q,      state_d;
  logic [OP_W-1:0] alu_op_q,     alu_op_d;
  logic [XLEN-1:0] alu_rs1_q,    alu_rs1_d;
  logic [XLEN-1:0] alu_rs2_q,    alu_rs2_d;
  logic [4:0]      rd_q,         rd_d;
  br_t             br_q,         br_d;
  logic            ill_q,        ill_d;
  logic [XLEN-1:0] out_result_q, out_result_d;
  logic [4:0]      out_rd_q,     out_rd_d;
  logic            out_taken_q,  out_taken_d;
  logic            out_ill_q,    out_ill_d;

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd_idx;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] shamt;
  logic            f7_base;
  logic            f7_alt;

  assign opcode  = IN_INSTR_i[6:0];
  assign rd_idx  = IN_INSTR_i[11:7];
  assign funct3  = IN_INSTR_i[14:12];
  assign funct7  = IN_INSTR_i[31:25];
  assign imm_i   = {{(XLEN-12){IN_INSTR_i[31]}}, IN_INSTR_i[31:20]};
  assign shamt   = {{(XLEN-5){1'b0}}, IN_INSTR_i[24:20]};
  assign f7_base = (funct7 == F7_BASE);
  assign f7_alt  = (funct7 == F7_ALT);

  // ---------------------------------------------------------------------------
  // Operand source (optional forwarding from the retiring result)
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

`ifdef ALU_SEQ_FWD_EN
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;
  logic       fwd_ok;

  assign rs1_idx = IN_INSTR_i[19:15];
  assign rs2_idx = IN_INSTR_i[24:20];
  // Only the same-edge retire/accept needs bypassing. By the time the sequencer is back in
  // IDLE, writeback has had a cycle to update the register file. x0 is never forwarded.
  assign fwd_ok  = (state_q == S_RESP) && OUT_READY_i && (out_rd_q != 5'd0);
  assign rs1_val = (fwd_ok && (rs1_idx == out_rd_q)) ? out_result_q : IN_RS1_i;
  // An I-type instruction never selects rs2_val, so its immediate bits (which share the
  // rs2 field) cannot cause a false bypass.
  assign rs2_val = (fwd_ok && (rs2_idx == out_rd_q)) ? out_result_q : IN_RS2_i;
`else
  assign rs1_val = IN_RS1_i;
  assign rs2_val = IN_RS2_i;
`endif

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [OP_W-1:0] dec_op;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic [4:0]      dec_rd;
  br_t             dec_br;
  logic            dec_ill;

  always_comb begin
    dec_op  = OP_AND;
    dec_a   = '0;
    dec_b   = '0;
    dec_rd  = 5'd0;
    dec_br  = BR_NONE;
    dec_ill = 1'b1;

    case (opcode)
      OPC_R: begin
        dec_a  = rs1_val;
        dec_b  = rs2_val;
        dec_rd = rd_idx;
        case (funct3)
          3'b000: begin
            if (f7_base) begin
              dec_op = OP_ADD; dec_ill = 1'b0;
            end else if (f7_alt) begin
              dec_op = OP_SUB; dec_ill = 1'b0;
            end
          end
          3'b001: if (f7_base) begin dec_op = OP_SLL;  dec_ill = 1'b0; end
          3'b010: if (f7_base) begin dec_op = OP_SLT;  dec_ill = 1'b0; end
          3'b011: if (f7_base) begin dec_op = OP_SLTU; dec_ill = 1'b0; end
          3'b100: if (f7_base) begin dec_op = OP_XOR;  dec_ill = 1'b0; end
          3'b101: begin
            if (f7_base) begin
              dec_op = OP_SRL; dec_ill = 1'b0;
            end else if (f7_alt) begin
              dec_op = OP_SRA; dec_ill = 1'b0;
            end
          end
          3'b110: if (f7_base) begin dec_op = OP_OR;   dec_ill = 1'b0; end
          default: if (f7_base) begin dec_op = OP_AND; dec_ill = 1'b0; end
        endcase
      end

      OPC_I: begin
        dec_a  = rs1_val;
        dec_b  = imm_i;
        dec_rd = rd_idx;
        case (funct3)
          3'b000: begin dec_op = OP_ADD;  dec_ill = 1'b0; end
          3'b010: begin dec_op = OP_SLT;  dec_ill = 1'b0; end
          3'b011: begin dec_op = OP_SLTU; dec_ill = 1'b0; end
          3'b100: begin dec_op = OP_XOR;  dec_ill = 1'b0; end
          3'b110: begin dec_op = OP_OR;   dec_ill = 1'b0; end
          3'b111: begin dec_op = OP_AND;  dec_ill = 1'b0; end
          3'b001: begin
            if (f7_base) begin
              dec_op = OP_SLL; dec_b = shamt; dec_ill = 1'b0;
            end
          end
          default: begin  // 3'b101
            if (f7_base) begin
              dec_op = OP_SRL; dec_b = shamt; dec_ill = 1'b0;
            end else if (f7_alt) begin
              dec_op = OP_SRA; dec_b = shamt; dec_ill = 1'b0;
            end
          end
        endcase
      end

      OPC_B: begin
        dec_a = rs1_val;
        dec_b = rs2_val;
        case (funct3)
          3'b000: begin dec_op = OP_SUB;  dec_br = BR_EQ; dec_ill = 1'b0; end
          3'b001: begin dec_op = OP_SUB;  dec_br = BR_NE; dec_ill = 1'b0; end
          3'b100: begin dec_op = OP_SLT;  dec_br = BR_LT; dec_ill = 1'b0; end
          3'b101: begin dec_op = OP_SLT;  dec_br = BR_GE; dec_ill = 1'b0; end
          3'b110: begin dec_op = OP_SLTU; dec_br = BR_LT; dec_ill = 1'b0; end
          3'b111: begin dec_op = OP_SLTU; dec_br = BR_GE; dec_ill = 1'b0; end
          default: ;
        endcase
      end

      default: ;
    endcase

    // An illegal instruction still passes through EXEC/RESP, but it presents quiet operands
    // to the ALU and has no destination register.
    if (dec_ill) begin
      dec_op = OP_AND;
      dec_a  = '0;
      dec_b  = '0;
      dec_rd = 5'd0;
      dec_br = BR_NONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake and next state
  // ---------------------------------------------------------------------------
  logic in_accept;

  assign IN_READY_o  = (state_q == S_IDLE) || ((state_q == S_RESP) && OUT_READY_i);
  assign in_accept   = IN_VALID_i && IN_READY_o;
  assign OUT_VALID_o = (state_q == S_RESP);

  always_comb begin
    state_d      = state_q;
    alu_op_d     = alu_op_q;
    alu_rs1_d    = alu_rs1_q;
    alu_rs2_d    = alu_rs2_q;
    rd_d         = rd_q;
    br_d         = br_q;
    ill_d        = ill_q;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;
    out_taken_d  = out_taken_q;
    out_ill_d    = out_ill_q;

    case (state_q)
      S_IDLE: begin
        if (IN_VALID_i) state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d      = S_RESP;
        out_result_d = ill_q ? '0 : ALU_RD_i;
        out_rd_d     = rd_q;
        out_ill_d    = ill_q;
        case (br_q)
          BR_EQ:   out_taken_d = ALU_ZR_i;
          BR_NE:   out_taken_d = !ALU_ZR_i;
          BR_LT:   out_taken_d = ALU_RD_i[0];
          BR_GE:   out_taken_d = !ALU_RD_i[0];
          default: out_taken_d = 1'b0;
        endcase
      end
      S_RESP: begin
        if (OUT_READY_i) state_d = IN_VALID_i ? S_EXEC : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Accepting an instruction always enters EXEC, so the ALU inputs change only on that
    // edge and stay constant otherwise.
    if (in_accept) begin
      alu_op_d  = dec_op;
      alu_rs1_d = dec_a;
      alu_rs2_d = dec_b;
      rd_d      = dec_rd;
      br_d      = dec_br;
      ill_d     = dec_ill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      alu_op_q     <= OP_AND;
      alu_rs1_q    <= '0;
      alu_rs2_q    <= '0;
      rd_q         <= 5'd0;
      br_q         <= BR_NONE;
      ill_q        <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= 5'd0;
      out_taken_q  <= 1'b0;
      out_ill_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_op_q     <= alu_op_d;
      alu_rs1_q    <= alu_rs1_d;
      alu_rs2_q    <= alu_rs2_d;
      rd_q         <= rd_d;
      br_q         <= br_d;
      ill_q        <= ill_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
      out_taken_q  <= out_taken_d;
      out_ill_q    <= out_ill_d;
    end
  end

  assign ALU_OP_o      = alu_op_q;
  assign ALU_RS1_o     = alu_rs1_q;
  assign ALU_RS2_o     = alu_rs2_q;
  assign OUT_RESULT_o  = out_result_q;
  assign OUT_RD_o      = out_rd_q;
  assign OUT_TAKEN_o   = out_taken_q;
  assign OUT_ILLEGAL_o = out_ill_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: bench for alu_sequencer with a behavioural ALU attached.
// Latency: the handshake edge moves the instruction into EXEC, and OUT_VALID_o is expected on the next edge.
// Backpressure: OUT_READY_i is stalled both in directed sequences and at random.

module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_rs1, in_rs2, out_result;
  logic [4:0]  out_rd;
  logic        out_taken, out_ill;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_rd;
  logic        alu_zr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .IN_VALID_i(in_valid), .IN_READY_o(in_ready), .IN_INSTR_i(in_instr),
    .IN_RS1_i(in_rs1), .IN_RS2_i(in_rs2),
    .OUT_VALID_o(out_valid), .OUT_READY_i(out_ready), .OUT_RESULT_o(out_result),
    .OUT_RD_o(out_rd), .OUT_TAKEN_o(out_taken), .OUT_ILLEGAL_o(out_ill),
    .ALU_OP_o(alu_op), .ALU_RS1_o(alu_a), .ALU_RS2_o(alu_b),
    .ALU_RD_i(alu_rd), .ALU_ZR_i(alu_zr)
  );

  // Behavioural combinational ALU.
  always_comb begin
    alu_rd = 32'd0;
    case (alu_op)
      4'b0000: alu_rd = alu_a & alu_b;
      4'b0001: alu_rd = alu_a | alu_b;
      4'b0010: alu_rd = alu_a + alu_b;
      4'b0011: alu_rd = {31'd0, alu_a == alu_b};
      4'b0100: alu_rd = alu_a << alu_b[4:0];
      4'b0101: alu_rd = alu_a >> alu_b[4:0];
      4'b0111: alu_rd = $signed(alu_a) >>> alu_b[4:0];
      4'b1000: alu_rd = alu_a ^ alu_b;
      4'b1001: alu_rd = ~(alu_a | alu_b);
      4'b1010: alu_rd = alu_a - alu_b;
      4'b1110: alu_rd = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'b1111: alu_rd = {31'd0, alu_a < alu_b};
      default: alu_rd = 32'd0;
    endcase
  end
  assign alu_zr = (alu_rd == 32'd0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
    return {7'd0, rs2, rs1, f3, 5'd0, 7'b1100011};
  endfunction

  // Reference model: RV32I semantics evaluated directly on the operand values.
  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        tk;
    logic        ill;
    logic        br;
  } exp_t;

  function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [4:0]  sh;
    f7  = ins[31:25];
    f3  = ins[14:12];
    imm = {{20{ins[31]}}, ins[31:20]};
    sh  = ins[24:20];
    e   = '{32'd0, 5'd0, 1'b0, 1'b0, 1'b0};
    case (ins[6:0])
      7'b0110011: begin
        e.rd = ins[11:7];
        case ({f7, f3})
          {7'h00, 3'd0}: e.res = a + b;
          {7'h20, 3'd0}: e.res = a - b;
          {7'h00, 3'd1}: e.res = a << b[4:0];
          {7'h00, 3'd2}: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          {7'h00, 3'd3}: e.res = (a < b) ? 32'd1 : 32'd0;
          {7'h00, 3'd4}: e.res = a ^ b;
          {7'h00, 3'd5}: e.res = a >> b[4:0];
          {7'h20, 3'd5}: e.res = $signed(a) >>> b[4:0];
          {7'h00, 3'd6}: e.res = a | b;
          {7'h00, 3'd7}: e.res = a & b;
          default:       e.ill = 1'b1;
        endcase
      end
      7'b0010011: begin
        e.rd = ins[11:7];
        case (f3)
          3'd0: e.res = a + imm;
          3'd2: e.res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
          3'd3: e.res = (a < imm) ? 32'd1 : 32'd0;
          3'd4: e.res = a ^ imm;
          3'd6: e.res = a | imm;
          3'd7: e.res = a & imm;
          3'd1: if (f7 == 7'h00) e.res = a << sh; else e.ill = 1'b1;
          default: begin
            if (f7 == 7'h00)      e.res = a >> sh;
            else if (f7 == 7'h20) e.res = $signed(a) >>> sh;
            else                  e.ill = 1'b1;
          end
        endcase
      end
      7'b1100011: begin
        e.br = 1'b1;
        case (f3)
          3'd0: e.tk = (a == b);
          3'd1: e.tk = (a != b);
          3'd4: e.tk = ($signed(a) < $signed(b));
          3'd5: e.tk = ($signed(a) >= $signed(b));
          3'd6: e.tk = (a < b);
          3'd7: e.tk = (a >= b);
          default: e.ill = 1'b1;
        endcase
      end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) e = '{32'd0, 5'd0, 1'b0, 1'b1, 1'b0};
    return e;
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        tk;
    logic        ill;
    logic [3:0]  op;
    logic        cres;
  } vec_t;

  vec_t vecs [20];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  // Drive one vector from IDLE: check the ALU op in EXEC, then the response one edge later.
  task automatic run_vec(input vec_t v, input int idx);
    in_instr  = v.instr;
    in_rs1    = v.a;
    in_rs2    = v.b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    wait_ready($sformatf("v%0d", idx));
    step();
    in_valid = 1'b0;
    chk($sformatf("v%0d_exec_op", idx), {28'd0, alu_op}, {28'd0, v.op});
    chk($sformatf("v%0d_exec_novalid", idx), {31'd0, out_valid}, 32'd0);
    step();
    chk($sformatf("v%0d_valid", idx), {31'd0, out_valid}, 32'd1);
    if (v.cres) chk($sformatf("v%0d_result", idx), out_result, v.res);
    chk($sformatf("v%0d_rd", idx), {27'd0, out_rd}, {27'd0, v.rd});
    chk($sformatf("v%0d_taken", idx), {31'd0, out_taken}, {31'd0, v.tk});
    chk($sformatf("v%0d_illegal", idx), {31'd0, out_ill}, {31'd0, v.ill});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk($sformatf("v%0d_retired", idx), {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_t        q[$];
    exp_t        r;
    exp_t        e;
    logic        acc, ret, have_r, hold_old;
    logic [31:0] a, b, exp_fwd;
    int          retired;

    in_valid = 1'b0; out_ready = 1'b0; in_instr = 32'd0; in_rs1 = 32'd0; in_rs2 = 32'd0;

    vecs[0]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'd15, 32'd10, 32'd25, 5'd3, 1'b0, 1'b0, 4'b0010, 1'b1};
    vecs[1]  = '{enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd5), 32'd15, 32'd10, 32'd5, 5'd5, 1'b0, 1'b0, 4'b1010, 1'b1};
    vecs[2]  = '{enc_i(12'h404, 5'd1, 3'd5, 5'd4), 32'h8000_0000, 32'd0, 32'hF800_0000, 5'd4, 1'b0, 1'b0, 4'b0111, 1'b1};
    vecs[3]  = '{enc_b(5'd2, 5'd1, 3'd0), 32'd5, 32'd5, 32'd0, 5'd0, 1'b1, 1'b0, 4'b1010, 1'b0};
    vecs[4]  = '{enc_b(5'd2, 5'd1, 3'd4), 32'd2, 32'd3, 32'd0, 5'd0, 1'b1, 1'b0, 4'b1110, 1'b0};
    vecs[5]  = '{enc_b(5'd2, 5'd1, 3'd7), 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd0, 1'b0, 1'b0, 4'b1111, 1'b0};
    vecs[6]  = '{32'h0000_007F, 32'd3, 32'd4, 32'd0, 5'd0, 1'b0, 1'b1, 4'b0000, 1'b1};
    vecs[7]  = '{enc_i(12'hFFF, 5'd1, 3'd0, 5'd7), 32'd0, 32'd9, 32'hFFFF_FFFF, 5'd7, 1'b0, 1'b0, 4'b0010, 1'b1};
    vecs[8]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd0), 32'hF0, 32'h0F, 32'hFF, 5'd0, 1'b0, 1'b0, 4'b1000, 1'b1};
    vecs[9]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd6), 32'd1, 32'hFFFF_FFFF, 32'd1, 5'd6, 1'b0, 1'b0, 4'b1111, 1'b1};
    vecs[10] = '{enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd3), 32'd6, 32'd7, 32'd0, 5'd0, 1'b0, 1'b1, 4'b0000, 1'b1};
    vecs[11] = '{enc_b(5'd2, 5'd1, 3'd1), 32'd5, 32'd5, 32'd0, 5'd0, 1'b0, 1'b0, 4'b1010, 1'b0};
    vecs[12] = '{enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd8), 32'd1, 32'h21, 32'd2, 5'd8, 1'b0, 1'b0, 4'b0100, 1'b1};
    vecs[13] = '{enc_i(12'hFFF, 5'd1, 3'd2, 5'd9), 32'h8000_0000, 32'd0, 32'd1, 5'd9, 1'b0, 1'b0, 4'b1110, 1'b1};
    vecs[14] = '{enc_i(12'h004, 5'd1, 3'd5, 5'd10), 32'h8000_0000, 32'd0, 32'h0800_0000, 5'd10, 1'b0, 1'b0, 4'b0101, 1'b1};
    vecs[15] = '{enc_b(5'd2, 5'd1, 3'd5), 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 1'b0, 1'b0, 4'b1110, 1'b0};
    vecs[16] = '{enc_i(12'h0F0, 5'd1, 3'd6, 5'd11), 32'h0F, 32'd0, 32'hFF, 5'd11, 1'b0, 1'b0, 4'b0001, 1'b1};
    vecs[17] = '{enc_i(12'h0F0, 5'd1, 3'd7, 5'd12), 32'hFF, 32'd0, 32'hF0, 5'd12, 1'b0, 1'b0, 4'b0000, 1'b1};
    vecs[18] = '{enc_i(12'h404, 5'd1, 3'd1, 5'd13), 32'd1, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 4'b0000, 1'b1};
    vecs[19] = '{enc_b(5'd2, 5'd1, 3'd2), 32'd1, 32'd2, 32'd0, 5'd0, 1'b0, 1'b1, 4'b0000, 1'b1};

    // Reset state.
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid_after", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
    chk("rst_out_taken", {31'd0, out_taken}, 32'd0);
    chk("rst_out_illegal", {31'd0, out_ill}, 32'd0);
    chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
    chk("rst_alu_rs1", alu_a, 32'd0);
    chk("rst_alu_rs2", alu_b, 32'd0);

    for (int i = 0; i < 20; i++) run_vec(vecs[i], i);

    // Five cycles of OUT_READY_i low with the next instruction waiting, then retire and
    // accept on the same edge.
    step();
    in_instr = vecs[0].instr; in_rs1 = 32'd15; in_rs2 = 32'd10; in_valid = 1'b1;
    step();
    in_instr = vecs[1].instr;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("stall%0d_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stall%0d_result", k), out_result, 32'd25);
      chk($sformatf("stall%0d_rd", k), {27'd0, out_rd}, 32'd3);
      chk($sformatf("stall%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    out_ready = 1'b0; in_valid = 1'b0;
    chk("b2b_exec_novalid", {31'd0, out_valid}, 32'd0);
    chk("b2b_exec_op", {28'd0, alu_op}, 32'b1010);
    chk("b2b_exec_rs1", alu_a, 32'd15);
    step();
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_result", out_result, 32'd5);
    chk("b2b_rd", {27'd0, out_rd}, 32'd5);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset while in EXEC drops the instruction.
    in_instr = vecs[0].instr; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rexec_op", {28'd0, alu_op}, 32'b0010);
    rst_n = 1'b0;
    #1;
    chk("rexec_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rexec_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rexec_alu_op", {28'd0, alu_op}, 32'd0);
    step();
    rst_n = 1'b1;
    step(); step(); step();
    chk("rexec_dropped", {31'd0, out_valid}, 32'd0);

    // ADDI x1,x0,7 retiring while ADD x2,x1,x1 is accepted on the same edge.
    in_instr = enc_i(12'd7, 5'd0, 3'd0, 5'd1); in_rs1 = 32'd0; in_rs2 = 32'd0; in_valid = 1'b1;
    step();
    in_instr = enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2);
    step();
    chk("fwd_first_result", out_result, 32'd7);
    chk("fwd_first_rd", {27'd0, out_rd}, 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0; in_valid = 1'b0;
    step();
`ifdef ALU_SEQ_FWD_EN
    exp_fwd = 32'd14;
`else
    exp_fwd = 32'd0;
`endif
    chk("fwd_second_result", out_result, exp_fwd);
    chk("fwd_second_rd", {27'd0, out_rd}, 32'd2);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Random traffic against the reference model.
    acc = 1'b0; retired = 0; have_r = 1'b0;
    r = '{32'd0, 5'd0, 1'b0, 1'b0, 1'b0};
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      hold_old = in_valid && !acc;
      if (!hold_old) begin
        in_valid = (cyc < 2900) && ($urandom_range(0, 9) < 7);
        case ($urandom_range(0, 9))
          0, 1, 2, 3: in_instr = enc_r(($urandom_range(0, 9) < 5) ? 7'h00 :
                                       (($urandom_range(0, 9) < 8) ? 7'h20 : 7'($urandom)),
                                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                       3'($urandom), 5'($urandom_range(0, 7)));
          4, 5, 6:    in_instr = enc_i(12'($urandom), 5'($urandom_range(0, 7)), 3'($urandom),
                                       5'($urandom_range(0, 7)));
          7, 8:       in_instr = enc_b(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom));
          default:    in_instr = $urandom;
        endcase
        in_rs1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
        in_rs2 = ($urandom_range(0, 3) == 0) ? in_rs1 : $urandom;
      end
      out_ready = (cyc >= 2900) || ($urandom_range(0, 9) < 6);
      @(negedge clk);
      acc = in_valid && in_ready;
      ret = out_valid && out_ready;
      have_r = 1'b0;
      if (ret) begin
        if (q.size() == 0) begin
          chk("rnd_unexpected_retire", 32'd1, 32'd0);
        end else begin
          r = q.pop_front();
          have_r = 1'b1;
          retired++;
          chk("rnd_rd", {27'd0, out_rd}, {27'd0, r.rd});
          chk("rnd_taken", {31'd0, out_taken}, {31'd0, r.tk});
          chk("rnd_illegal", {31'd0, out_ill}, {31'd0, r.ill});
          if (!r.br) chk("rnd_result", out_result, r.res);
        end
      end
      if (acc) begin
        a = in_rs1;
        b = in_rs2;
`ifdef ALU_SEQ_FWD_EN
        if (have_r && r.rd != 5'd0) begin
          if (in_instr[19:15] == r.rd) a = r.res;
          if ((in_instr[6:0] == 7'b0110011 || in_instr[6:0] == 7'b1100011) && in_instr[24:20] == r.rd)
            b = r.res;
        end
`endif
        e = ref_model(in_instr, a, b);
        q.push_back(e);
      end
    end
    chk("rnd_drained", q.size(), 32'd0);
    chk("rnd_enough_retired", {31'd0, retired > 500}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
